// File: rtl/flex_serial_tx_ctrl.sv
// Transmit-side controller for a flex_pts_sr: frames each accepted word
// as start(0), data LSB first, stop(1), one bit every BIT_PERIOD clocks.
module flex_serial_tx_ctrl #(
   parameter int DATA_BITS  = 16,
   parameter int BIT_PERIOD = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [DATA_BITS+1:0] frame_out,
   output logic                 load_enable,
   output logic                 shift_enable,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int CW = $clog2(DATA_BITS + 2);

   localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
   localparam logic [CW-1:0] C_LAST = CW'(DATA_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_t;

   state_t               state;
   state_t               nxt_state;
   logic [DATA_BITS-1:0] data_reg;
   logic [DATA_BITS-1:0] nxt_data;
   logic [TW-1:0]        bit_timer;
   logic [TW-1:0]        nxt_timer;
   logic [CW-1:0]        bit_cnt;
   logic [CW-1:0]        nxt_cnt;
   logic                 bit_end;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         data_reg  <= '0;
         bit_timer <= '0;
         bit_cnt   <= '0;
      end else begin
         state     <= nxt_state;
         data_reg  <= nxt_data;
         bit_timer <= nxt_timer;
         bit_cnt   <= nxt_cnt;
      end
   end

   assign bit_end = (bit_timer == T_LAST);

   // Strobes depend only on registered state, never on data_valid.
   always_comb begin
      nxt_state    = state;
      nxt_data     = data_reg;
      nxt_timer    = bit_timer;
      nxt_cnt      = bit_cnt;
      data_ready   = 1'b0;
      load_enable  = 1'b0;
      shift_enable = 1'b0;
      tx_done      = 1'b0;
      unique case (state)
         IDLE: begin
            data_ready = 1'b1;
            if (data_valid) begin
               nxt_data  = data_in;
               nxt_state = LOAD;
            end
         end
         LOAD: begin
            load_enable = 1'b1;
            nxt_timer   = '0;
            nxt_cnt     = '0;
            nxt_state   = SEND;
         end
         SEND: begin
            if (!bit_end) begin
               nxt_timer = bit_timer + TW'(1);
            end else if (bit_cnt != C_LAST) begin
               shift_enable = 1'b1;
               nxt_cnt      = bit_cnt + CW'(1);
               nxt_timer    = '0;
            end else begin
               tx_done   = 1'b1;
               nxt_timer = '0;
               nxt_cnt   = '0;
               nxt_state = IDLE;
            end
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   assign tx_busy   = (state != IDLE);
   assign frame_out = {1'b1, data_reg, 1'b0};

endmodule

// File: tb/tb_flex_serial_tx_ctrl.sv
// Bench for flex_serial_tx_ctrl: directed vector table, hand sequences
// and randomized traffic decoded from a modelled serial line.
module tb_flex_serial_tx_ctrl;

   localparam int M_ONE   = 0;
   localparam int M_HOLD  = 1;
   localparam int M_NOISE = 2;
   localparam int NV      = 5;
   localparam int NW      = 70;

   typedef struct {
      logic [7:0] d;
      logic [0:9] ser;
      int         mode;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   logic clk   = 1'b0;
   logic rst_a;
   logic rst_b;
   logic rst_r;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int t,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0d got=%h want=%h",
                  nm, t, got, exp);
      end
   endtask

   // DATA_BITS=8, BIT_PERIOD=4
   logic [7:0] a_data;
   logic       a_valid;
   logic       a_ready;
   logic [9:0] a_frame;
   logic       a_load;
   logic       a_shift;
   logic       a_busy;
   logic       a_done;
   logic [9:0] a_sr;
   logic       a_ser;

   flex_serial_tx_ctrl #(
      .DATA_BITS (8),
      .BIT_PERIOD(4)
   ) u_dut_a (
      .clk         (clk),
      .n_rst       (rst_a),
      .data_in     (a_data),
      .data_valid  (a_valid),
      .data_ready  (a_ready),
      .frame_out   (a_frame),
      .load_enable (a_load),
      .shift_enable(a_shift),
      .tx_busy     (a_busy),
      .tx_done     (a_done)
   );

   always @(posedge clk or negedge rst_a)
      if (!rst_a)       a_sr <= '1;
      else if (a_load)  a_sr <= a_frame;
      else if (a_shift) a_sr <= {1'b1, a_sr[9:1]};
   assign a_ser = a_sr[0];

   // DATA_BITS=4, BIT_PERIOD=1
   logic [3:0] b_data;
   logic       b_valid;
   logic       b_ready;
   logic [5:0] b_frame;
   logic       b_load;
   logic       b_shift;
   logic       b_busy;
   logic       b_done;
   logic [5:0] b_sr;
   logic       b_ser;

   flex_serial_tx_ctrl #(
      .DATA_BITS (4),
      .BIT_PERIOD(1)
   ) u_dut_b (
      .clk         (clk),
      .n_rst       (rst_b),
      .data_in     (b_data),
      .data_valid  (b_valid),
      .data_ready  (b_ready),
      .frame_out   (b_frame),
      .load_enable (b_load),
      .shift_enable(b_shift),
      .tx_busy     (b_busy),
      .tx_done     (b_done)
   );

   always @(posedge clk or negedge rst_b)
      if (!rst_b)       b_sr <= '1;
      else if (b_load)  b_sr <= b_frame;
      else if (b_shift) b_sr <= {1'b1, b_sr[5:1]};
   assign b_ser = b_sr[0];

   // Random traffic, one instance per bit period.
   for (genvar g = 0; g < 3; g++) begin : gr
      localparam int BP = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
      logic [7:0] d;
      logic       v;
      logic       rdy, ld, sh, bsy, dn;
      logic [9:0] fo;
      logic [9:0] sr;
      logic       ser;
      logic [7:0] words [NW];
      int         sent;
      int         rcvd;
      logic       fin;
      int         cyc;
      int         sc;
      logic       act;
      logic       seen;
      logic [9:0] fb;

      flex_serial_tx_ctrl #(
         .DATA_BITS (8),
         .BIT_PERIOD(BP)
      ) u_dut (
         .clk         (clk),
         .n_rst       (rst_r),
         .data_in     (d),
         .data_valid  (v),
         .data_ready  (rdy),
         .frame_out   (fo),
         .load_enable (ld),
         .shift_enable(sh),
         .tx_busy     (bsy),
         .tx_done     (dn)
      );

      always @(posedge clk or negedge rst_r)
         if (!rst_r)   sr <= '1;
         else if (ld)  sr <= fo;
         else if (sh)  sr <= {1'b1, sr[9:1]};
      assign ser = sr[0];

      initial begin
         v    = 1'b0;
         d    = '0;
         sent = 0;
         fin  = 1'b0;
         wait (rst_r === 1'b1);
         for (int i = 0; i < NW; i++) begin
            int w;
            @(posedge clk);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            d        = 8'($urandom);
            v        = 1'b1;
            words[i] = d;
            w        = 0;
            @(negedge clk);
            while (!rdy && w < 400) begin
               @(negedge clk);
               w++;
            end
            chk("rnd_ready", i, 32'(rdy), 32'd1);
            if (!rdy) break;
            @(posedge clk);
            #1;
            v = 1'b0;
            sent++;
         end
         repeat (BP * 12 + 10) @(posedge clk);
         fin = 1'b1;
      end

      // Decode the line purely from its timing: a frame is the 10*BP
      // cycles after the line first drops, each bit held BP cycles.
      initial begin
         act  = 1'b0;
         seen = 1'b0;
         cyc  = 0;
         sc   = 0;
         rcvd = 0;
         fb   = '0;
         forever begin
            @(negedge clk);
            if (rst_r === 1'b1) begin
               if (ld || sh)
                  chk("rnd_overlap", g, 32'(ld & sh), 32'd0);
               if (ld) begin
                  if (seen) chk("rnd_shifts", g, sc, 32'd9);
                  sc   = 0;
                  seen = 1'b1;
               end
               if (sh) sc++;
               if (!act && !ser) begin
                  act = 1'b1;
                  cyc = 0;
               end
               if (act) begin
                  if (cyc % BP == 0) fb[cyc/BP] = ser;
                  else chk("rnd_hold", cyc, 32'(ser),
                           32'(fb[cyc/BP]));
                  if (dn || cyc == 10 * BP - 1)
                     chk("rnd_done", cyc, 32'(dn),
                         32'(cyc == 10 * BP - 1));
                  cyc++;
                  if (cyc == 10 * BP) begin
                     act = 1'b0;
                     if (rcvd < NW)
                        chk("rnd_frame", rcvd, 32'(fb),
                            32'({1'b1, words[rcvd], 1'b0}));
                     else
                        chk("rnd_extra", rcvd, 32'(rcvd), NW);
                     rcvd++;
                  end
               end
            end
         end
      end
   end

   task automatic run_frame(input logic [7:0] d,
                            input logic [0:9] ser,
                            input int mode,
                            input logic [7:0] nxt);
      logic [5:0] got;
      logic [5:0] exp;
      logic       sh;
      logic       eb;
      for (int t = 0; t < 42; t++) begin
         @(negedge clk);
         sh  = (t >= 5) && (t <= 37) && ((t - 5) % 4 == 0);
         eb  = (t < 2) ? 1'b1 : ser[(t-2)/4];
         exp = {t == 0, t == 1, sh, t >= 1, t == 41, eb};
         got = {a_ready, a_load, a_shift, a_busy, a_done, a_ser};
         chk("frame_cycle", t, 32'(got), 32'(exp));
         if (t == 1 || t == 41)
            chk("frame_out", t, 32'(a_frame),
                32'({1'b1, d, 1'b0}));
         @(posedge clk);
         #1;
         if (mode == M_HOLD) begin
            a_valid = 1'b1;
            a_data  = nxt;
         end else if (mode == M_NOISE && t + 1 <= 41) begin
            a_valid = (t % 2 == 0);
            a_data  = 8'h3C;
         end else begin
            a_valid = 1'b0;
         end
      end
   endtask

   vec_t       tbl [NV];
   logic [4:0] bexp [9];

   initial begin
      tbl[0] = '{d: 8'hA5, ser: 10'b0101001011, mode: M_ONE};
      tbl[1] = '{d: 8'hFF, ser: 10'b0111111111, mode: M_HOLD};
      tbl[2] = '{d: 8'h00, ser: 10'b0000000001, mode: M_ONE};
      tbl[3] = '{d: 8'h81, ser: 10'b0100000011, mode: M_NOISE};
      tbl[4] = '{d: 8'h3C, ser: 10'b0001111001, mode: M_ONE};
      // {ready, load, shift, done, serial}
      bexp = '{5'b10001, 5'b01001, 5'b00100, 5'b00100, 5'b00101,
               5'b00101, 5'b00100, 5'b00011, 5'b10001};

      rst_a   = 1'b0;
      rst_b   = 1'b0;
      rst_r   = 1'b0;
      a_valid = 1'b0;
      a_data  = '0;
      b_valid = 1'b0;
      b_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_r = 1'b1;

      @(negedge clk);
      chk("reset_state", 0,
          32'({a_ready, a_load, a_shift, a_busy, a_done, a_ser}),
          32'b100001);
      chk("reset_frame", 0, 32'(a_frame), 32'h200);
      repeat (3) begin
         @(negedge clk);
         chk("idle_quiet", 0,
             32'({a_ready, a_load, a_shift, a_busy, a_done}),
             32'b10000);
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < NV; i++) begin
         if (i == 0 || tbl[i-1].mode != M_HOLD) begin
            a_valid = 1'b1;
            a_data  = tbl[i].d;
         end
         run_frame(tbl[i].d, tbl[i].ser, tbl[i].mode,
                   (i + 1 < NV) ? tbl[i+1].d : 8'h00);
      end
      @(negedge clk);
      chk("after_last", 0,
          32'({a_ready, a_load, a_busy, a_ser}), 32'b1001);

      // Asynchronous reset in the middle of a frame.
      @(posedge clk);
      #1;
      a_valid = 1'b1;
      a_data  = 8'h5A;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      chk("pre_rst_busy", 0, 32'(a_busy), 32'd1);
      rst_a = 1'b0;
      #1;
      chk("rst_async", 0,
          32'({a_ready, a_load, a_shift, a_busy, a_done, a_ser}),
          32'b100001);
      chk("rst_frame", 0, 32'(a_frame), 32'h200);
      @(posedge clk);
      #2;
      rst_a = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk("post_rst", t,
             32'({a_ready, a_load, a_shift, a_busy, a_ser}),
             32'b10001);
      end

      // BIT_PERIOD = 1, DATA_BITS = 4.
      @(posedge clk);
      #1;
      b_valid = 1'b1;
      b_data  = 4'h6;
      for (int t = 0; t < 9; t++) begin
         @(negedge clk);
         chk("bp1_cycle", t,
             32'({b_ready, b_load, b_shift, b_done, b_ser}),
             32'(bexp[t]));
         if (t >= 1 && t <= 7)
            chk("bp1_busy", t, 32'(b_busy), 32'd1);
         @(posedge clk);
         #1;
         b_valid = 1'b0;
      end

      for (int c = 0; c < 20000; c++) begin
         if (gr[0].fin && gr[1].fin && gr[2].fin) break;
         @(posedge clk);
      end
      chk("rnd_finish", 0,
          32'({gr[0].fin, gr[1].fin, gr[2].fin}), 32'b111);
      chk("rnd_count0", 0, gr[0].rcvd, gr[0].sent);
      chk("rnd_count1", 1, gr[1].rcvd, gr[1].sent);
      chk("rnd_count2", 2, gr[2].rcvd, gr[2].sent);
      chk("rnd_total", 0,
          gr[0].sent + gr[1].sent + gr[2].sent, 3 * NW);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
